// File: rtl/acquisition_controller.sv
// Acquisition sequencer: arms on START, optionally waits for an index edge, streams
// disc-reader bytes into RAM, and stops on abort, index count or RAM full.
module acquisition_controller #(
  parameter int ADDR_BITS = 19,
  parameter int IDX_BITS  = 8
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic                 WAIT_INDEX,
  input  logic [IDX_BITS-1:0]  IDX_COUNT,
  input  logic                 INDEX,
  input  logic                 MDR_WRITE,
  input  logic [7:0]           MDR_DATA,
  output logic                 MDR_RUN,
  output logic [ADDR_BITS-1:0] RAM_ADDR,
  output logic [7:0]           RAM_DATA,
  output logic                 RAM_WE,
  output logic                 BUSY,
  output logic                 WAITING,
  output logic                 DONE,
  output logic [2:0]           STATUS
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_IDX = 2'd1,
    ST_ACQ      = 2'd2,
    ST_FLUSH    = 2'd3
  } state_t;

  localparam logic [ADDR_BITS-1:0] ADDR_MAX  = {ADDR_BITS{1'b1}};
  localparam logic [ADDR_BITS-1:0] ADDR_ONE  = {{(ADDR_BITS-1){1'b0}}, 1'b1};
  localparam logic [ADDR_BITS-1:0] ADDR_ZERO = {ADDR_BITS{1'b0}};
  localparam logic [IDX_BITS-1:0]  IDX_ONE   = {{(IDX_BITS-1){1'b0}}, 1'b1};
  localparam logic [IDX_BITS-1:0]  IDX_ZERO  = {IDX_BITS{1'b0}};

  state_t                 state_q, state_d;
  logic                   flush_q, flush_d;
  logic                   index_prev_q;
  logic [IDX_BITS-1:0]    idx_cnt_q, idx_cnt_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [7:0]             data_q, data_d;
  logic                   we_q, we_d;
  logic                   full_q, full_d;
  logic                   run_q, run_d;
  logic                   busy_q, busy_d;
  logic                   waiting_q, waiting_d;
  logic                   done_q, done_d;
  logic [2:0]             status_q, status_d;

  logic                   index_rise_s;
  logic                   full_land_s;
  logic                   write_accept_s;
  logic                   idx_hit_s;
  logic [IDX_BITS-1:0]    idx_next_s;

  // A write landing on the top address marks RAM full and blocks the strobe in the same cycle
  assign index_rise_s   = INDEX & ~index_prev_q;
  assign full_land_s    = we_q & (addr_q == ADDR_MAX);
  assign write_accept_s = MDR_WRITE & ((state_q == ST_ACQ) | (state_q == ST_FLUSH))
                          & ~full_q & ~full_land_s;
  assign idx_next_s     = idx_cnt_q + IDX_ONE;
  assign idx_hit_s      = (state_q == ST_ACQ) & index_rise_s & ~ABORT
                          & (IDX_COUNT != IDX_ZERO) & (idx_next_s == IDX_COUNT);

  // State register
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
    end
  end

  // Next-state logic; flush_q marks the second FLUSH cycle
  always_comb begin
    state_d = state_q;
    flush_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = WAIT_INDEX ? ST_WAIT_IDX : ST_ACQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_IDX: begin
        if (ABORT) begin
          state_d = ST_FLUSH;
        end else if (index_rise_s) begin
          state_d = ST_ACQ;
        end else begin
          state_d = ST_WAIT_IDX;
        end
      end
      ST_ACQ: begin
        if (ABORT || idx_hit_s || full_land_s) begin
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_ACQ;
        end
      end
      ST_FLUSH: begin
        if (flush_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FLUSH;
          flush_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output and datapath next values; START clearing overrides a late full landing in IDLE
  always_comb begin
    we_d      = write_accept_s;
    data_d    = write_accept_s ? MDR_DATA : data_q;
    addr_d    = (we_q && (addr_q != ADDR_MAX)) ? (addr_q + ADDR_ONE) : addr_q;
    idx_cnt_d = idx_cnt_q;
    full_d    = full_q | full_land_s;
    status_d  = status_q;
    if (full_land_s) begin
      status_d[1] = 1'b1;
    end else begin
      status_d[1] = status_q[1];
    end
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          addr_d    = ADDR_ZERO;
          idx_cnt_d = IDX_ZERO;
          status_d  = 3'b000;
          full_d    = 1'b0;
        end else begin
          idx_cnt_d = idx_cnt_q;
        end
      end
      ST_WAIT_IDX: begin
        if (ABORT) begin
          status_d[2] = 1'b1;
        end else begin
          status_d[2] = status_q[2];
        end
      end
      ST_ACQ: begin
        if (index_rise_s) begin
          idx_cnt_d = idx_next_s;
        end else begin
          idx_cnt_d = idx_cnt_q;
        end
        if (ABORT) begin
          status_d[2] = 1'b1;
        end else if (idx_hit_s) begin
          status_d[0] = 1'b1;
        end else begin
          status_d[0] = status_q[0];
        end
      end
      ST_FLUSH: begin
        idx_cnt_d = idx_cnt_q;
      end
      default: begin
        idx_cnt_d = idx_cnt_q;
      end
    endcase
    run_d     = (state_d == ST_ACQ);
    busy_d    = (state_d != ST_IDLE);
    waiting_d = (state_d == ST_WAIT_IDX);
    done_d    = (state_q == ST_FLUSH) && flush_q;
  end

  // Datapath and registered outputs
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      index_prev_q <= 1'b0;
      idx_cnt_q    <= IDX_ZERO;
      addr_q       <= ADDR_ZERO;
      data_q       <= 8'h00;
      we_q         <= 1'b0;
      full_q       <= 1'b0;
      run_q        <= 1'b0;
      busy_q       <= 1'b0;
      waiting_q    <= 1'b0;
      done_q       <= 1'b0;
      status_q     <= 3'b000;
    end else begin
      index_prev_q <= INDEX;
      idx_cnt_q    <= idx_cnt_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      we_q         <= we_d;
      full_q       <= full_d;
      run_q        <= run_d;
      busy_q       <= busy_d;
      waiting_q    <= waiting_d;
      done_q       <= done_d;
      status_q     <= status_d;
    end
  end

  assign MDR_RUN  = run_q;
  assign RAM_ADDR = addr_q;
  assign RAM_DATA = data_q;
  assign RAM_WE   = we_q;
  assign BUSY     = busy_q;
  assign WAITING  = waiting_q;
  assign DONE     = done_q;
  assign STATUS   = status_q;

endmodule

// File: tb/tb_acquisition_controller.sv
// Self-checking bench for acquisition_controller: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural model of the acquisition rules.
module tb_acquisition_controller;
  localparam int AW = 4;
  localparam logic [AW-1:0] MAXA = {AW{1'b1}};
  localparam int P_IDLE = 0, P_WAIT = 1, P_ACQ = 2, P_FLUSH = 3;

  logic          CLOCK = 1'b0;
  logic          RESET, START, ABORT, WAIT_INDEX, INDEX, MDR_WRITE;
  logic [7:0]    IDX_COUNT, MDR_DATA;
  logic          MDR_RUN, RAM_WE, BUSY, WAITING, DONE;
  logic [AW-1:0] RAM_ADDR;
  logic [7:0]    RAM_DATA;
  logic [2:0]    STATUS;

  acquisition_controller #(.ADDR_BITS(AW), .IDX_BITS(8)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .START(START), .ABORT(ABORT),
    .WAIT_INDEX(WAIT_INDEX), .IDX_COUNT(IDX_COUNT), .INDEX(INDEX),
    .MDR_WRITE(MDR_WRITE), .MDR_DATA(MDR_DATA), .MDR_RUN(MDR_RUN),
    .RAM_ADDR(RAM_ADDR), .RAM_DATA(RAM_DATA), .RAM_WE(RAM_WE), .BUSY(BUSY),
    .WAITING(WAITING), .DONE(DONE), .STATUS(STATUS)
  );

  always #5 CLOCK = ~CLOCK;

  int checks = 0;
  int failures = 0;
  int we_cnt = 0;
  int done_cnt = 0;
  logic [AW-1:0] log_addr[$];
  logic [7:0]    log_data[$];

  // reference model state
  int            m_ph;
  int            m_fl;
  logic          m_prev, m_we, m_full, m_done;
  logic [7:0]    m_cnt, m_data;
  logic [AW-1:0] m_addr;
  logic [2:0]    m_stat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = P_IDLE; m_fl = 0; m_prev = 1'b0; m_we = 1'b0; m_full = 1'b0;
    m_done = 1'b0; m_cnt = 8'h00; m_data = 8'h00; m_addr = '0; m_stat = 3'b000;
  endtask

  // One clock of the acquisition rules applied to the inputs seen at this edge
  task automatic model_step();
    logic rise, landed, accept;
    rise   = INDEX && !m_prev;
    landed = m_we && (m_addr == MAXA);
    accept = MDR_WRITE && (m_ph == P_ACQ || m_ph == P_FLUSH) && !m_full && !landed;
    m_prev = INDEX;
    if (m_we && m_addr != MAXA) m_addr = m_addr + 1'b1;
    m_we = accept;
    if (accept) m_data = MDR_DATA;
    if (landed) begin m_full = 1'b1; m_stat[1] = 1'b1; end
    m_done = 1'b0;
    case (m_ph)
      P_IDLE: if (START) begin
        m_addr = '0; m_cnt = 8'h00; m_stat = 3'b000; m_full = 1'b0;
        m_ph = WAIT_INDEX ? P_WAIT : P_ACQ;
      end
      P_WAIT: begin
        if (ABORT) begin m_stat[2] = 1'b1; m_ph = P_FLUSH; m_fl = 0; end
        else if (rise) m_ph = P_ACQ;
      end
      P_ACQ: begin
        if (rise) m_cnt = m_cnt + 8'd1;
        if (ABORT) begin m_stat[2] = 1'b1; m_ph = P_FLUSH; m_fl = 0; end
        else if (rise && IDX_COUNT != 8'd0 && m_cnt == IDX_COUNT) begin
          m_stat[0] = 1'b1; m_ph = P_FLUSH; m_fl = 0;
        end
        if (landed) begin m_ph = P_FLUSH; m_fl = 0; end
      end
      default: begin
        if (m_fl == 1) begin m_ph = P_IDLE; m_done = 1'b1; m_fl = 0; end
        else m_fl = 1;
      end
    endcase
  endtask

  task automatic compare_all();
    chk("mdr_run", 32'(MDR_RUN), 32'(m_ph == P_ACQ));
    chk("busy", 32'(BUSY), 32'(m_ph != P_IDLE));
    chk("waiting", 32'(WAITING), 32'(m_ph == P_WAIT));
    chk("done", 32'(DONE), 32'(m_done));
    chk("ram_we", 32'(RAM_WE), 32'(m_we));
    chk("ram_addr", 32'(RAM_ADDR), 32'(m_addr));
    chk("ram_data", 32'(RAM_DATA), 32'(m_data));
    chk("status", 32'(STATUS), 32'(m_stat));
  endtask

  task automatic tick();
    @(posedge CLOCK);
    model_step();
    #1;
    compare_all();
    if (RAM_WE) begin
      we_cnt++;
      log_addr.push_back(RAM_ADDR);
      log_data.push_back(RAM_DATA);
    end
    if (DONE) done_cnt++;
  endtask

  task automatic step(input logic st, input logic ab, input logic wr,
                      input logic [7:0] d, input logic idx);
    START = st; ABORT = ab; MDR_WRITE = wr; MDR_DATA = d; INDEX = idx;
    tick();
    START = 1'b0; ABORT = 1'b0; MDR_WRITE = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (BUSY && n < 40) begin
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      n++;
    end
    if (BUSY) chk("idle_timeout", 32'(BUSY), 32'd0);
  endtask

  task automatic mid_reset();
    #2;
    RESET = 1'b0;
    model_reset();
    #1;
    chk("rst_mdr_run", 32'(MDR_RUN), 32'd0);
    chk("rst_ram_we", 32'(RAM_WE), 32'd0);
    chk("rst_ram_addr", 32'(RAM_ADDR), 32'd0);
    compare_all();
    #1;
    RESET = 1'b1;
  endtask

  initial begin
    int d0;
    RESET = 1'b0; START = 1'b0; ABORT = 1'b0; WAIT_INDEX = 1'b0; INDEX = 1'b0;
    MDR_WRITE = 1'b0; IDX_COUNT = 8'd0; MDR_DATA = 8'h00;
    model_reset();
    #22;
    compare_all();
    RESET = 1'b1;

    // index stop after two edges, five bytes stored
    WAIT_INDEX = 1'b0; IDX_COUNT = 8'd2;
    log_addr.delete(); log_data.delete(); d0 = done_cnt;
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 8'h11 + 8'(i), 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    wait_idle();
    chk("t1_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("t1_status", 32'(STATUS), 32'd1);
    chk("t1_addr", 32'(RAM_ADDR), 32'd5);
    chk("t1_nwrites", 32'(log_addr.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < log_addr.size()) begin
        chk("t1_waddr", 32'(log_addr[i]), 32'(i));
        chk("t1_wdata", 32'(log_data[i]), 32'h11 + 32'(i));
      end
    end

    // armed: writes ignored until the index edge
    WAIT_INDEX = 1'b1; IDX_COUNT = 8'd0;
    log_addr.delete(); log_data.delete();
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'h40 + 8'(i), 1'b0);
    chk("t2_waiting", 32'(WAITING), 32'd1);
    chk("t2_no_we", 32'(log_addr.size()), 32'd0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("t2_run", 32'(MDR_RUN), 32'd1);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    wait_idle();

    // fill the RAM
    WAIT_INDEX = 1'b0; IDX_COUNT = 8'd0;
    log_addr.delete(); log_data.delete(); we_cnt = 0;
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, 8'(i), 1'b0);
    wait_idle();
    chk("t3_we_pulses", 32'(we_cnt), 32'd16);
    if (log_addr.size() > 0) chk("t3_last_addr", 32'(log_addr[log_addr.size()-1]), 32'd15);
    chk("t3_status", 32'(STATUS), 32'd2);
    chk("t3_addr", 32'(RAM_ADDR), 32'd15);

    // abort with a write in the same cycle
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h01, 1'b0);
    step(1'b0, 1'b1, 1'b1, 8'hA5, 1'b0);
    chk("t4_we", 32'(RAM_WE), 32'd1);
    chk("t4_data", 32'(RAM_DATA), 32'hA5);
    chk("t4_status", 32'(STATUS), 32'd4);
    chk("t4_done_early", 32'(DONE), 32'd0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("t4_done_f2", 32'(DONE), 32'd0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("t4_done", 32'(DONE), 32'd1);

    // trailing write in the second FLUSH cycle after index stop
    IDX_COUNT = 8'd1;
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h33, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("t5_done_early", 32'(DONE), 32'd0);
    step(1'b0, 1'b0, 1'b1, 8'h5A, 1'b0);
    chk("t5_done", 32'(DONE), 32'd1);
    chk("t5_we", 32'(RAM_WE), 32'd1);
    chk("t5_data", 32'(RAM_DATA), 32'h5A);
    chk("t5_status", 32'(STATUS), 32'd1);

    // START while busy is ignored, then asynchronous reset mid-acquisition
    IDX_COUNT = 8'd0;
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h61, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h62, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("t6_busy", 32'(BUSY), 32'd1);
    chk("t6_addr_kept", 32'(RAM_ADDR), 32'd2);
    mid_reset();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      logic st, ab, wr, ix;
      st = ($urandom_range(0, 99) < 12);
      ab = ($urandom_range(0, 39) == 0);
      wr = 1'($urandom_range(0, 1));
      ix = ($urandom_range(0, 3) == 0);
      if (st) begin
        WAIT_INDEX = 1'($urandom_range(0, 1));
        IDX_COUNT  = 8'($urandom_range(0, 3));
      end
      step(st, ab, wr, 8'($urandom), ix);
      if ($urandom_range(0, 299) == 0) mid_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
